// File: rtl/bc_station_ctrl.sv
// Barcode station sequencer: accepts a destination, drives until that station ID is read, then buzzes.
// Latency: state and flags update on the edge after an accepted command or ID; the clear handshakes are same-cycle.
// Backpressure: cmd_rdy is held off (not acked) while buzzing; IDs are cleared in the same cycle they are seen.
module bc_station_ctrl #(
  parameter logic [23:0] TIMEOUT_CYC = 24'd10_000_000,
  parameter logic [15:0] BUZZ_CYC    = 16'd50_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_rdy,
  input  logic [7:0] cmd,
  output logic       clr_cmd_rdy,
  input  logic       ID_vld,
  input  logic [7:0] ID,
  output logic       clr_ID_vld,
  output logic       go,
  output logic       buzz,
  output logic       at_dest,
  output logic       timeout,
  output logic       bad_id,
  output logic [3:0] stn_cnt
);

  typedef enum logic [1:0] {IDLE, MOVING, BUZZ, FAULT} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  dest;
  logic [23:0] timer;
  logic [15:0] buzz_cnt;

  logic accept;
  logic arrive;
  logic reload;
  logic mark_bad;
  logic id_is_stn;
  logic cmd_unused;

  assign id_is_stn  = (ID[7:6] == 2'b00);
  assign cmd_unused = ^cmd[7:6];

  // Moore-style status outputs; the fault flag lives exactly as long as FAULT
  assign go      = (state == MOVING);
  assign buzz    = (state == BUZZ);
  assign timeout = (state == FAULT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake decode; a command always outranks an ID, a matching ID outranks the timer
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    arrive      = 1'b0;
    reload      = 1'b0;
    mark_bad    = 1'b0;
    clr_cmd_rdy = 1'b0;
    clr_ID_vld  = 1'b0;
    if (rst_n) begin
      // Every ID is consumed whatever the state; only MOVING evaluates it
      clr_ID_vld  = ID_vld;
      accept      = cmd_rdy && (state != BUZZ);
      clr_cmd_rdy = accept;
    end
    case (state)
      IDLE: begin
        if (accept) state_nxt = MOVING;
      end
      MOVING: begin
        if (accept) begin
          state_nxt = MOVING;
        end else if (ID_vld) begin
          if (id_is_stn && (ID[5:0] == dest)) begin
            state_nxt = BUZZ;
            arrive    = 1'b1;
          end else if (id_is_stn) begin
            reload = 1'b1;
          end else begin
            mark_bad = 1'b1;
          end
        end else if (timer == 24'd0) begin
          state_nxt = FAULT;
        end
      end
      BUZZ: begin
        if (buzz_cnt <= 16'd1) state_nxt = IDLE;
      end
      FAULT: begin
        if (accept) state_nxt = MOVING;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: destination, station counter, sticky bad-ID flag, watchdog timer, buzz length, arrival pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dest     <= 6'd0;
      timer    <= 24'd0;
      buzz_cnt <= 16'd0;
      stn_cnt  <= 4'd0;
      bad_id   <= 1'b0;
      at_dest  <= 1'b0;
    end else begin
      at_dest <= arrive;
      if (accept) begin
        dest    <= cmd[5:0];
        timer   <= TIMEOUT_CYC;
        stn_cnt <= 4'd0;
        bad_id  <= 1'b0;
      end else begin
        if (state == MOVING) begin
          if (reload)                timer <= TIMEOUT_CYC;
          else if (timer != 24'd0)   timer <= timer - 24'd1;
        end else begin
          timer <= 24'd0;
        end
        if (reload && (stn_cnt != 4'd15)) stn_cnt <= stn_cnt + 4'd1;
        if (mark_bad)                     bad_id  <= 1'b1;
      end
      if (arrive)                                     buzz_cnt <= BUZZ_CYC;
      else if ((state == BUZZ) && (buzz_cnt != 16'd0)) buzz_cnt <= buzz_cnt - 16'd1;
    end
  end

endmodule

// File: tb/tb_bc_station_ctrl.sv
// Bench for bc_station_ctrl: directed scenarios plus a randomized phase against a behavioural model.
// The model tracks elapsed time since the last reload and remaining buzz length rather than counters.
// Stimulus emulates command source and decoder: each holds its level until it sees the clear.
module tb_bc_station_ctrl;
  localparam int T = 20;
  localparam int B = 5;
  localparam int M_IDLE = 0, M_MOV = 1, M_BUZZ = 2, M_FAULT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_rdy = 1'b0;
  logic [7:0] cmd = 8'h00;
  logic       ID_vld = 1'b0;
  logic [7:0] ID = 8'h00;
  logic       clr_cmd_rdy, clr_ID_vld, go, buzz, at_dest, timeout, bad_id;
  logic [3:0] stn_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc = 0;
  bit saw_clr_cmd, saw_clr_id;

  // behavioural model state
  int         m_mode;
  logic [5:0] m_dest;
  int         m_cnt, m_age, m_bleft;
  bit         m_bad;

  bc_station_ctrl #(.TIMEOUT_CYC(24'd20), .BUZZ_CYC(16'd5)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_rdy(cmd_rdy), .cmd(cmd), .clr_cmd_rdy(clr_cmd_rdy),
    .ID_vld(ID_vld), .ID(ID), .clr_ID_vld(clr_ID_vld), .go(go), .buzz(buzz),
    .at_dest(at_dest), .timeout(timeout), .bad_id(bad_id), .stn_cnt(stn_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_mode = M_IDLE; m_dest = 6'd0; m_cnt = 0; m_age = 0; m_bleft = 0; m_bad = 0;
  endfunction

  // One clock of the model, from the inputs present during this cycle
  function automatic void model_step();
    if (cmd_rdy && m_mode != M_BUZZ) begin
      m_mode = M_MOV; m_dest = cmd[5:0]; m_cnt = 0; m_bad = 0; m_age = 0;
    end else begin
      case (m_mode)
        M_MOV: begin
          if (ID_vld) begin
            if (ID[7:6] == 2'b00 && ID[5:0] == m_dest) begin
              m_mode = M_BUZZ; m_bleft = B;
            end else if (ID[7:6] == 2'b00) begin
              if (m_cnt < 15) m_cnt++;
              m_age = 0;
            end else begin
              m_bad = 1; m_age++;
            end
          end else if (m_age >= T) begin
            m_mode = M_FAULT;
          end else begin
            m_age++;
          end
        end
        M_BUZZ: begin
          if (m_bleft == 1) m_mode = M_IDLE;
          else m_bleft--;
        end
        default: ;
      endcase
    end
  endfunction

  // Compare every output at the falling edge, advance the model, then emulate the clearing sources
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!rst_n) model_reset();
    chk("go", go, m_mode == M_MOV);
    chk("buzz", buzz, m_mode == M_BUZZ);
    chk("timeout", timeout, m_mode == M_FAULT);
    chk("at_dest", at_dest, (m_mode == M_BUZZ) && (m_bleft == B));
    chk("bad_id", bad_id, m_bad);
    chk("stn_cnt", stn_cnt, m_cnt);
    chk("clr_cmd_rdy", clr_cmd_rdy, rst_n && cmd_rdy && (m_mode != M_BUZZ));
    chk("clr_ID_vld", clr_ID_vld, rst_n && ID_vld);
    saw_clr_cmd = clr_cmd_rdy;
    saw_clr_id  = clr_ID_vld;
    if (clr_cmd_rdy) last_acc = cyc;
    if (rst_n) model_step();
    @(posedge clk);
    #1;
    if (saw_clr_cmd) cmd_rdy = 1'b0;
    if (saw_clr_id)  ID_vld  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_cmd(input logic [7:0] c, output int n);
    cmd = c; cmd_rdy = 1'b1; n = 0;
    while (cmd_rdy && n < 50) begin n++; tick(); end
    chk("cmd_ack_bound", cmd_rdy, 1'b0);
  endtask

  task automatic send_id(input logic [7:0] v);
    int n;
    ID = v; ID_vld = 1'b1; n = 0;
    while (ID_vld && n < 50) begin n++; tick(); end
    chk("id_clear_bound", ID_vld, 1'b0);
    chk("id_clear_cycles", n, 1);
  endtask

  task automatic wait_buzz_end();
    int n = 0;
    while (buzz && n < 50) begin n++; tick(); end
    chk("buzz_end_bound", buzz, 1'b0);
  endtask

  task automatic wait_timeout();
    int n = 0;
    while (!timeout && n < 100) begin n++; tick(); end
    chk("timeout_reached", timeout, 1'b1);
    chk("timeout_cycle", cyc + 1 - last_acc, T + 2);
  endtask

  initial begin
    int n;
    model_reset();
    // reset
    idle(3);
    chk("rst_go", go, 1'b0);
    chk("rst_stn_cnt", stn_cnt, 4'd0);
    chk("rst_timeout", timeout, 1'b0);
    rst_n = 1'b1;
    idle(2);

    // 1: first command
    send_cmd(8'h05, n);
    chk("t1_ack_cycles", n, 1);
    chk("t1_go", go, 1'b1);
    chk("t1_stn_cnt", stn_cnt, 4'd0);

    // 2: two passing stations then the destination
    idle(9); send_id(8'h03);
    idle(9); send_id(8'h04);
    idle(9); send_id(8'h05);
    chk("t2_at_dest", at_dest, 1'b1);
    chk("t2_stn_cnt", stn_cnt, 4'd2);
    chk("t2_go", go, 1'b0);
    n = 0;
    while (buzz && n < 50) begin n++; tick(); end
    chk("t2_buzz_len", n, B);
    chk("t2_at_dest_gone", at_dest, 1'b0);

    // 3: no IDs -> timeout after exactly T+2 cycles, then a new command clears it
    send_cmd(8'h07, n);
    n = 1;
    while (go && n < 100) begin n++; tick(); end
    chk("t3_go_cycles", n - 1, T + 1);
    chk("t3_timeout", timeout, 1'b1);
    chk("t3_fault_cycle", cyc + 1 - last_acc, T + 2);
    send_cmd(8'h07, n);
    chk("t3_timeout_clr", timeout, 1'b0);
    chk("t3_go_again", go, 1'b1);

    // 4: non-station ID does not reload the timer
    idle(5);
    send_id(8'hC7);
    chk("t4_bad_id", bad_id, 1'b1);
    chk("t4_stn_cnt", stn_cnt, 4'd0);
    chk("t4_go", go, 1'b1);
    wait_timeout();

    // 5: command and ID in the same cycle, command wins
    send_cmd(8'h09, n);
    chk("t5_bad_cleared", bad_id, 1'b0);
    idle(3);
    cmd = 8'h02; cmd_rdy = 1'b1; ID = 8'h02; ID_vld = 1'b1;
    tick();
    chk("t5_clr_cmd", saw_clr_cmd, 1'b1);
    chk("t5_clr_id", saw_clr_id, 1'b1);
    chk("t5_no_arrival", at_dest, 1'b0);
    chk("t5_go", go, 1'b1);
    idle(3);
    send_id(8'h02);
    chk("t5_arrival", at_dest, 1'b1);
    wait_buzz_end();

    // 6: command held off during buzz, then reset mid-move
    send_cmd(8'h03, n);
    idle(2);
    send_id(8'h03);
    send_cmd(8'h04, n);
    chk("t6_ack_after_buzz", n, B + 1);
    chk("t6_go", go, 1'b1);
    idle(3);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_go", go, 1'b0);
    chk("t6_rst_buzz", buzz, 1'b0);
    cmd = 8'h06; cmd_rdy = 1'b1;
    idle(2);
    chk("t6_pending", cmd_rdy, 1'b1);
    rst_n = 1'b1;
    send_cmd(8'h06, n);
    chk("t6_post_rst_ack", n, 1);
    chk("t6_post_rst_go", go, 1'b1);

    // randomized phase
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if (!cmd_rdy && $urandom_range(0, 39) == 0) begin
        cmd = {2'($urandom_range(0, 3)), 3'b000, 3'($urandom_range(0, 7))};
        cmd_rdy = 1'b1;
      end
      if (!ID_vld && $urandom_range(0, 7) == 0) begin
        ID = {($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
              3'b000, 3'($urandom_range(0, 7))};
        ID_vld = 1'b1;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
